selector_mux: RTL and testbench



---
 rtl/selector_mux.sv | 44 ++++
 tb/tb_selector_mux.sv | 105 ++++++++++
 2 files changed

// File: rtl/selector_mux.sv
// selector_mux -- registered 2:1 data selector.
//
// Steers one of two equal-width sources onto a single registered output.
// A single select bit chooses the source for every bit of the word, and the
// result is captured on the rising edge of clk. The output therefore lags
// the inputs by exactly one cycle and never shows intermediate combinations
// of sel and data that occur between edges.
//
// Ports:
//   clk    in   1      clock; all state changes on the rising edge
//   rst_n  in   1      synchronous active-low reset; clears out to 0
//   sel    in   1      source select: 0 -> in0, 1 -> in1
//   in0    in   WIDTH  data source 0
//   in1    in   WIDTH  data source 1
//   out    out  WIDTH  registered selected data
module selector_mux #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  // Next value. Reset is folded in here so the flop below stays a plain D
  // register; reset only takes effect when it is sampled at an edge.
  always_comb begin
    out_d = sel ? in1 : in0;
    if (!rst_n) out_d = '0;
  end

  always_ff @(posedge clk) begin
    out_q <= out_d;
  end

  // Output is driven only from the flop: no combinational input-to-output path.
  assign out = out_q;

endmodule

// File: tb/tb_selector_mux.sv
module tb_selector_mux;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, sel;
  logic [7:0] a0, a1, y8;
  logic       b0, b1, y1;

  selector_mux #(.WIDTH(8)) u_w8 (.clk(clk), .rst_n(rst_n), .sel(sel), .in0(a0), .in1(a1), .out(y8));
  selector_mux #(.WIDTH(1)) u_w1 (.clk(clk), .rst_n(rst_n), .sel(sel), .in0(b0), .in1(b1), .out(y1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: out after an edge = rst * (sel*in1 + (1-sel)*in0),
  // evaluated with integer arithmetic on the values sampled at that edge.
  int         ms, mr, mv8, mv1;
  logic [7:0] m8;
  logic       m1;
  bit         mvalid = 1'b0;

  always @(posedge clk) begin
    ms  = (sel === 1'b1) ? 1 : 0;
    mr  = (rst_n === 1'b1) ? 1 : 0;
    mv8 = mr * (ms * int'(a1) + (1 - ms) * int'(a0));
    mv1 = mr * (ms * int'(b1) + (1 - ms) * int'(b0));
    m8  = mv8[7:0];
    m1  = mv1[0];
    if (rst_n === 1'b0) mvalid = 1'b1;
  end

  // Every-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_w8", y8, m8);
      chk("model_w1", {7'd0, y1}, {7'd0, m1});
    end
  end

  task automatic step(input logic r, input logic s, input logic [7:0] x0, input logic [7:0] x1,
                      input logic z0, input logic z1);
    rst_n = r; sel = s; a0 = x0; a1 = x1; b0 = z0; b1 = z1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b1; sel = 1'b0; a0 = '0; a1 = '0; b0 = 1'b0; b1 = 1'b0;
    @(negedge clk);

    // Reset for two edges with all-ones inputs selected.
    step(0, 1, 8'hFF, 8'hFF, 1, 1); chk("rst_edge1_w1", {7'd0, y1}, 8'h00); chk("rst_edge1_w8", y8, 8'h00);
    step(0, 1, 8'hFF, 8'hFF, 1, 1); chk("rst_edge2_w1", {7'd0, y1}, 8'h00); chk("rst_edge2_w8", y8, 8'h00);
    // Release: no dead cycle.
    step(1, 1, 8'hFF, 8'hFF, 1, 1); chk("release_w1", {7'd0, y1}, 8'h01); chk("release_w8", y8, 8'hFF);

    // Source selection at WIDTH=1.
    step(1, 0, 8'h00, 8'h00, 0, 1); chk("sel0_in0", {7'd0, y1}, 8'h00);
    step(1, 1, 8'h00, 8'h00, 0, 1); chk("sel1_in1", {7'd0, y1}, 8'h01);
    step(1, 0, 8'h00, 8'h00, 1, 0); chk("sel0_swap", {7'd0, y1}, 8'h01);
    step(1, 1, 8'h00, 8'h00, 1, 0); chk("sel1_swap", {7'd0, y1}, 8'h00);

    // Per-cycle switching of sel: out follows with one cycle lag.
    for (int i = 0; i < 6; i++) begin
      step(1, i[0], 8'h00, 8'h00, 0, 1);
      chk("toggle", {7'd0, y1}, {7'd0, i[0]});
    end

    // Inputs changing between edges must not reach out.
    step(1, 1, 8'h5A, 8'hC3, 0, 1); chk("pre_hold_w8", y8, 8'hC3);
    sel = 1'b0; a0 = 8'h11; b0 = 1'b0;
    #1; chk("hold_w8", y8, 8'hC3); chk("hold_w1", {7'd0, y1}, 8'h01);

    // Mid-stream reset pulse.
    step(1, 1, 8'h00, 8'hEE, 0, 1); chk("pre_mrst", {7'd0, y1}, 8'h01);
    rst_n = 1'b0;
    #1; chk("mrst_between_edges_w1", {7'd0, y1}, 8'h01); chk("mrst_between_edges_w8", y8, 8'hEE);
    step(0, 1, 8'h00, 8'hEE, 0, 1); chk("mrst_edge_w1", {7'd0, y1}, 8'h00); chk("mrst_edge_w8", y8, 8'h00);
    step(1, 1, 8'h00, 8'hEE, 0, 1); chk("mrst_after_w1", {7'd0, y1}, 8'h01); chk("mrst_after_w8", y8, 8'hEE);

    // WIDTH=8 data, plus model pins.
    step(1, 0, 8'hA5, 8'h3C, 0, 0); chk("w8_sel0", y8, 8'hA5); chk("model_pin_a5", m8, 8'hA5);
    step(1, 1, 8'hA5, 8'h3C, 0, 0); chk("w8_sel1", y8, 8'h3C); chk("model_pin_3c", m8, 8'h3C);

    // Exhaustive sel/in0/in1 at WIDTH=1.
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 2; x++)
        for (int z = 0; z < 2; z++) begin
          step(1, s[0], 8'h00, 8'h00, x[0], z[0]);
          chk("exh_w1", {7'd0, y1}, (s != 0) ? 8'(z) : 8'(x));
        end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
